// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared types, constants and helpers for the CRC engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    // Common generator polynomials (implicit top term omitted)
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

    // Widest vector the generic reversal helper handles
    localparam int REFLECT_MAX_W = 64;

    // Reverse the low 'width' bits of 'value'; bits above 'width' return zero
    function automatic logic [REFLECT_MAX_W-1:0] reflect(
        input logic [REFLECT_MAX_W-1:0] value,
        input int                       width
    );
        logic [REFLECT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REFLECT_MAX_W; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc_step
//  Description : Combinational fold of BITS_PER_CYC message bits into a CRC
//                value, MSB (i_data[BITS_PER_CYC-1]) first.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_step #(
    parameter int               CRC_W        = 32,
    parameter int               BITS_PER_CYC = 1,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(32'h04C11DB7)
) (
    input  logic [CRC_W-1:0]        i_crc,
    input  logic [BITS_PER_CYC-1:0] i_data,
    output logic [CRC_W-1:0]        o_crc
);

    // Unrolled chain of single-bit LFSR steps
    always_comb begin : p_fold
        logic [CRC_W-1:0] v;
        logic             fb;
        v  = i_crc;
        fb = 1'b0;
        for (int b = BITS_PER_CYC - 1; b >= 0; b--) begin
            fb = v[CRC_W-1] ^ i_data[b];
            v  = {v[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        o_crc = v;
    end

endmodule : crc_step
`default_nettype wire

// File: rtl/crc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_engine
//  Description : Parametrised multi-word CRC generator. Folds one DATA_W-bit
//                word per accepted crc_start into a running CRC register,
//                BITS_PER_CYC bits per clock, with start/busy/ready handshake.
//                Words chain into one message CRC until crc_reset.
//  Options     : `define CRC_REFLECT_EN  - fold words LSB first and reflect
//                the output (zlib CRC-32 style). Default: MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W        = 32,
    parameter int               DATA_W       = 32,
    parameter int               BITS_PER_CYC = 1,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT         = '1,
    parameter logic [CRC_W-1:0] XOR_OUT      = '1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DATA_W-1:0] data_in,
    input  logic              crc_reset,
    input  logic              crc_start,
    output logic              crc_busy,
    output logic              crc_ready,
    output logic [CRC_W-1:0]  crc_out
);

    localparam int              STEPS  = DATA_W / BITS_PER_CYC;
    localparam int              CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    crc_state_t        r_state;
    crc_state_t        w_state_nxt;
    logic [CRC_W-1:0]  r_crc;
    logic [CRC_W-1:0]  w_crc_step;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_word;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;

    // Word ordering and output presentation (reflected build swaps bit order)
`ifdef CRC_REFLECT_EN
    assign w_word  = DATA_W'(reflect(REFLECT_MAX_W'(data_in), DATA_W));
    assign crc_out = CRC_W'(reflect(REFLECT_MAX_W'(r_crc), CRC_W)) ^ XOR_OUT;
`else
    assign w_word  = data_in;
    assign crc_out = r_crc ^ XOR_OUT;
`endif

    // Top BITS_PER_CYC bits of the shift register are folded each SHIFT cycle
    crc_step #(
        .CRC_W        (CRC_W),
        .BITS_PER_CYC (BITS_PER_CYC),
        .POLY         (POLY)
    ) u_step (
        .i_crc  (r_crc),
        .i_data (r_shift[DATA_W-1 -: BITS_PER_CYC]),
        .o_crc  (w_crc_step)
    );

    // Next-state and handshake outputs; crc_reset overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        crc_busy    = (r_state == SHIFT);
        crc_ready   = (r_state == DONE);
        if (crc_reset) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (crc_start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                SHIFT: begin
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and datapath; CRC is kept across words for chaining
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (crc_reset) begin
                r_crc   <= INIT;
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_shift <= w_word;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_crc   <= w_crc_step;
                r_shift <= r_shift << BITS_PER_CYC;
                if (r_cnt != C_LAST) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule : crc_engine
`default_nettype wire

// File: tb/tb_crc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_engine
//  Description : Self-checking bench for crc_engine. Instance A: 32-bit words,
//                1 bit/cycle, INIT=0, XOR_OUT=0. Instances B/C: byte words,
//                8 bits/cycle, default INIT; C has XOR_OUT=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_engine;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] a_data;
    logic        a_rst, a_start, a_busy, a_ready;
    logic [31:0] a_out;
    logic [7:0]  b_data;
    logic        b_rst, b_start, b_busy, b_ready, c_busy, c_ready;
    logic [31:0] b_out, c_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    int b_rdy_q[$];
    bit a_msg[$];
    bit b_msg[$];

    always #5 CLK = ~CLK;

    crc_engine #(
        .CRC_W(32), .DATA_W(32), .BITS_PER_CYC(1),
        .POLY(POLY), .INIT(32'h0), .XOR_OUT(32'h0)
    ) u_dut_a (
        .CLK(CLK), .nRST(nRST), .data_in(a_data), .crc_reset(a_rst),
        .crc_start(a_start), .crc_busy(a_busy), .crc_ready(a_ready), .crc_out(a_out)
    );

    crc_engine #(
        .CRC_W(32), .DATA_W(8), .BITS_PER_CYC(8)
    ) u_dut_b (
        .CLK(CLK), .nRST(nRST), .data_in(b_data), .crc_reset(b_rst),
        .crc_start(b_start), .crc_busy(b_busy), .crc_ready(b_ready), .crc_out(b_out)
    );

    crc_engine #(
        .CRC_W(32), .DATA_W(8), .BITS_PER_CYC(8), .XOR_OUT(32'h0)
    ) u_dut_c (
        .CLK(CLK), .nRST(nRST), .data_in(b_data), .crc_reset(b_rst),
        .crc_start(b_start), .crc_busy(c_busy), .crc_ready(c_ready), .crc_out(c_out)
    );

    // Cycle stamps of B ready pulses, sampled mid-cycle
    always @(negedge CLK) begin
        cyc_cnt++;
        if (b_ready) b_rdy_q.push_back(cyc_cnt);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word as it enters the message bit stream (low dw bits, sent MSB first)
    function automatic logic [31:0] word_bits(input logic [31:0] w, input int dw);
        logic [31:0] r;
        r = w;
`ifdef CRC_REFLECT_EN
        r = '0;
        for (int i = 0; i < dw; i++) r[i] = w[dw-1-i];
`endif
        return r;
    endfunction

    // Reference CRC of a whole message, as polynomial long division over its bits
    function automatic logic [31:0] model_crc(input logic [31:0] init, input logic [31:0] xo,
                                              input bit msg[$]);
        logic [31:0] r;
        logic [31:0] o;
        r = init;
        foreach (msg[i]) begin
            if (r[31] ^ msg[i]) r = (r << 1) ^ POLY;
            else                r = (r << 1);
        end
        o = r;
`ifdef CRC_REFLECT_EN
        for (int i = 0; i < 32; i++) o[i] = r[31-i];
`endif
        return o ^ xo;
    endfunction

    // One word through A; optionally pokes a conflicting start mid-shift
    task automatic a_word(input logic [31:0] w, input bit inject);
        int cyc;
        logic [31:0] ew;
        @(negedge CLK);
        a_data = w; a_start = 1'b1;
        @(posedge CLK); #1;
        a_start = 1'b0; a_data = $urandom;
        ew = word_bits(w, 32);
        for (int k = 31; k >= 0; k--) a_msg.push_back(ew[k]);
        cyc = 1;
        check_val("a_busy_after_accept", 64'(a_busy), 64'(1));
        while (!a_ready && cyc < 60) begin
            if (inject && cyc == 5) begin
                a_start = 1'b1; a_data = ~w;
            end else begin
                a_start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        a_start = 1'b0;
        // start presented in cycle 0; ready expected in cycle DATA_W/BPC+1
        check_val("a_latency", 64'(cyc), 64'(33));
        check_val("a_busy_in_done", 64'(a_busy), 64'(0));
        check_val("a_crc", 64'(a_out), 64'(model_crc(32'h0, 32'h0, a_msg)));
        @(posedge CLK); #1;
        check_val("a_ready_one_cycle", 64'(a_ready), 64'(0));
    endtask

    task automatic a_clear();
        @(negedge CLK); a_rst = 1'b1;
        @(posedge CLK); #1; a_rst = 1'b0;
        a_msg.delete();
        check_val("a_out_after_crc_reset", 64'(a_out), 64'(0));
    endtask

    task automatic b_word(input logic [7:0] w);
        int cyc;
        logic [31:0] ew;
        @(negedge CLK);
        b_data = w; b_start = 1'b1;
        @(posedge CLK); #1;
        b_start = 1'b0;
        ew = word_bits(32'(w), 8);
        for (int k = 7; k >= 0; k--) b_msg.push_back(ew[k]);
        cyc = 1;
        while (!b_ready && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check_val("b_latency", 64'(cyc), 64'(2));
        check_val("b_crc", 64'(b_out), 64'(model_crc(32'hFFFFFFFF, 32'hFFFFFFFF, b_msg)));
        check_val("c_crc", 64'(c_out), 64'(model_crc(32'hFFFFFFFF, 32'h0, b_msg)));
    endtask

    task automatic b_clear();
        @(negedge CLK); b_rst = 1'b1;
        @(posedge CLK); #1; b_rst = 1'b0;
        b_msg.delete();
        check_val("b_out_after_crc_reset", 64'(b_out), 64'(0));
        check_val("c_out_after_crc_reset", 64'(c_out), 64'(32'hFFFFFFFF));
    endtask

    initial begin : p_main
        int rdy;
        logic [31:0] exp_b, exp_c, exp_a1;
        nRST = 1'b0;
        a_data = '0; a_rst = 1'b0; a_start = 1'b0;
        b_data = '0; b_rst = 1'b0; b_start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("reset_a_busy",  64'(a_busy),  64'(0));
        check_val("reset_a_ready", 64'(a_ready), 64'(0));
        check_val("reset_a_out",   64'(a_out),   64'(0));
        check_val("reset_b_out",   64'(b_out),   64'(0));
        check_val("reset_c_out",   64'(c_out),   64'(32'hFFFFFFFF));
        @(negedge CLK); nRST = 1'b1;

        // Single word 0x00000001 with zero INIT/XOR
        a_word(32'h00000001, 1'b0);
`ifdef CRC_REFLECT_EN
        exp_a1 = model_crc(32'h0, 32'h0, a_msg);
`else
        exp_a1 = 32'h04C11DB7;
`endif
        check_val("a_single_one", 64'(a_out), 64'(exp_a1));
        a_clear();

        // Random multi-word messages, some with ignored mid-shift starts
        for (int m = 0; m < 5; m++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) a_word($urandom, 1'($urandom_range(0, 1)));
            a_clear();
        end

        // Abort in the middle of a shift
        @(negedge CLK); a_data = $urandom; a_start = 1'b1;
        @(posedge CLK); #1; a_start = 1'b0;
        repeat (9) begin @(posedge CLK); #1; end
        a_rst = 1'b1;
        @(posedge CLK); #1; a_rst = 1'b0;
        check_val("abort_busy", 64'(a_busy), 64'(0));
        check_val("abort_out",  64'(a_out),  64'(0));
        rdy = 0;
        repeat (40) begin @(posedge CLK); #1; if (a_ready) rdy++; end
        check_val("abort_no_ready", 64'(rdy), 64'(0));

        // crc_reset and crc_start together: start is dropped
        @(negedge CLK); a_rst = 1'b1; a_start = 1'b1; a_data = $urandom;
        @(posedge CLK); #1;
        check_val("rst_start_busy", 64'(a_busy), 64'(0));
        a_rst = 1'b0; a_start = 1'b0;
        @(posedge CLK); #1;
        check_val("rst_start_still_idle", 64'(a_busy), 64'(0));

        // Asynchronous reset mid-shift
        @(negedge CLK); a_data = $urandom; a_start = 1'b1;
        @(posedge CLK); #1; a_start = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        nRST = 1'b0;
        #1;
        check_val("nrst_busy",  64'(a_busy),  64'(0));
        check_val("nrst_ready", 64'(a_ready), 64'(0));
        check_val("nrst_out",   64'(a_out),   64'(0));
        @(negedge CLK); nRST = 1'b1;
        a_msg.delete();

        // "123456789" as back-to-back bytes with start held high
        b_rdy_q.delete();
        @(posedge CLK); #1;
        for (int i = 0; i < 9; i++) begin
            b_data = 8'h31 + 8'(i); b_start = 1'b1;
            @(posedge CLK); #1;
            if (i == 8) b_start = 1'b0;
            @(posedge CLK); #1;
            check_val("b2b_ready", 64'(b_ready), 64'(1));
        end
        @(posedge CLK); #1;
`ifdef CRC_REFLECT_EN
        exp_b = 32'hCBF43926; exp_c = 32'h340BC6D9;
`else
        exp_b = 32'hFC891918; exp_c = 32'h0376E6E7;
`endif
        check_val("check_123456789", 64'(b_out), 64'(exp_b));
        check_val("check_123456789_noxor", 64'(c_out), 64'(exp_c));
        check_val("b2b_ready_count", 64'(b_rdy_q.size()), 64'(9));
        for (int i = 1; i < b_rdy_q.size(); i++)
            check_val("b2b_ready_spacing", 64'(b_rdy_q[i] - b_rdy_q[i-1]), 64'(2));
        b_clear();

        // Random byte messages on B/C
        for (int m = 0; m < 3; m++) begin
            int nb;
            nb = $urandom_range(2, 6);
            for (int w = 0; w < nb; w++) b_word(8'($urandom));
            b_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_crc_engine
`default_nettype wire

// File: doc/crc_engine.md
Name: crc_engine

Overview:
Parametrised successor to the team's bit-serial CRC-32 generator. It folds one DATA_W-bit word per command into a running CRC register, processing BITS_PER_CYC bits per clock. The generator polynomial, initial value and final XOR are parameters. It has a start/busy/ready handshake and supports multi-word messages, and sits between the control register block and the power-rail/status logic.

Parameters:
CRC_W, 32, width of CRC register and polynomial
DATA_W, 32, width of one input word; multiple of BITS_PER_CYC
BITS_PER_CYC, 1, bits folded per clock; 1..DATA_W, divides DATA_W
POLY, 32'h04C11DB7, generator polynomial, implicit x^CRC_W term omitted
INIT, all-ones, CRC register value after reset/crc_reset
XOR_OUT, all-ones, value XORed onto register to form crc_out

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
data_in  input  DATA_W  word to fold; sampled only on accepted crc_start
crc_reset  input  1  synchronous clear of CRC register to INIT; aborts any operation
crc_start  input  1  request to fold data_in; accepted only when not busy
crc_busy  output  1  high while shifting a word
crc_ready  output  1  one-cycle pulse when a word has been fully folded
crc_out  output  CRC_W  crc_q ^ XOR_OUT; valid whenever crc_busy is low

Behaviour:
- Reset (nRST low, async): state=IDLE, crc_q=INIT, shift register=0, bit counter=0, crc_busy=0, crc_ready=0, crc_out=INIT^XOR_OUT.
- States: IDLE, SHIFT, DONE.
- IDLE, or DONE, with crc_start=1 and crc_reset=0: latch data_in into the shift register, clear the counter, go to SHIFT. crc_busy=1 from the next cycle.
- SHIFT, each cycle: fold BITS_PER_CYC bits, MSB first.
- Per-bit step: fb = crc_q[CRC_W-1] ^ d; crc_q = {crc_q[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- SHIFT counter: shift register moves left by BITS_PER_CYC and the counter increments. When the counter reaches DATA_W/BITS_PER_CYC-1, go to DONE.
- Latency: crc_ready is asserted DATA_W/BITS_PER_CYC+1 cycles after the accepting edge.
- DONE: crc_ready=1 for exactly one cycle, crc_busy=0, then IDLE. A crc_start in DONE is accepted (back-to-back words, no bubble beyond DONE).
- crc_start while in SHIFT: ignored and not queued; crc_q is unaffected.
- crc_q is NOT reinitialised between words. Consecutive words chain into one message CRC; software issues crc_reset to begin a new message.
- crc_reset=1 in any state: next cycle crc_q=INIT, state=IDLE, counter=0, crc_ready=0.
- crc_reset and crc_start in the same cycle: reset wins, start is dropped.
- Counter width: $clog2(DATA_W/BITS_PER_CYC), minimum 1. No wrap beyond terminal count.
- crc_out is combinational from registered crc_q. Mid-SHIFT values are intermediate and must not be sampled.

Optional Feature:
CRC_REFLECT_EN
- Defined: each input word is bit-reversed before folding (LSB first), and crc_out = reverse(crc_q) ^ XOR_OUT. This gives standard CRC-32 (zlib) semantics.
- Undefined: MSB-first, unreflected output (CRC-32/BZIP2 semantics).
- Timing and handshake are identical in both builds.

Decomposition:
- Package crc_pkg:
  - state enum crc_state_t {IDLE, SHIFT, DONE}
  - localparam CRC32_POLY=32'h04C11DB7
  - CRC16_CCITT_POLY=16'h1021
  - function reflect() for generic bit reversal
- Sub-module crc_step: purely combinational. Applies BITS_PER_CYC serial steps (unrolled loop) to crc and data bits, parametrised on CRC_W/POLY/BITS_PER_CYC. Instantiated once in crc_engine.

Test Plan:
- INIT=0, XOR_OUT=0, BITS_PER_CYC=1: reset, start with data_in=32'h00000001 -> crc_ready pulse 33 cycles after the start edge, crc_out=32'h04C11DB7.
- DATA_W=8, BITS_PER_CYC=8, defaults: nine back-to-back words "123456789" (8'h31..8'h39) -> final crc_out=32'hFC891918. With CRC_REFLECT_EN -> 32'hCBF43926. crc_ready is high 9 times, 2 cycles apart.
- XOR_OUT=0, same nine bytes -> crc_out=32'h0376E6E7 (CRC-32/MPEG-2).
- Mid-SHIFT abort: start word, assert crc_reset at cycle 10 -> next cycle crc_busy=0, crc_out=INIT^XOR_OUT=0, no crc_ready pulse.
- Start during SHIFT with a different data_in -> ignored. Result equals the single-word expected value, exactly one crc_ready.
- crc_reset and crc_start in the same cycle -> stays IDLE, crc_busy stays 0. Also assert nRST low mid-SHIFT -> outputs return to reset values immediately.
